seg7_status_scan: RTL

//   Drives the 4-digit seven-segment display from the automated-test checker's status.

---
 rtl/seg7_status_scan_pkg.sv | 30 +++
 rtl/seg7_status_scan_if.sv | 24 ++
 rtl/seg7_status_scan_hex_decode.sv | 36 +++
 rtl/seg7_status_scan.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/seg7_status_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_status_scan_pkg
//  Purpose  : Shared definitions for the checker-status seven-segment scanner:
//             display mode encodings, fixed glyphs and digit-enable patterns.
//             All glyphs are active-low {dp,g,f,e,d,c,b,a}; dp stays off.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_status_scan_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_DONE = 2'd1,
        MODE_ERR  = 2'd2
    } mode_t;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_S     = 8'h92;
    localparam logic [7:0] GLYPH_U     = 8'hC1;
    localparam logic [7:0] GLYPH_C     = 8'hC6;

    localparam logic [3:0] DIGIT_EN_OFF = 4'b1111;

    // Active-low one-hot enable for slot idx; slot 0 is the leftmost digit.
    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_status_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_status_scan_if
//  Purpose  : Bundles the checker status inputs and the display outputs.
//  Signals  : test_pass, test_err  checker flags (level)
//             pc[31:0]             reference writeback PC, [15:0] used
//             seg_en[3:0]          digit enables, active-low, [3] leftmost
//             seg[7:0]             segments, active-low {dp,g,f,e,d,c,b,a}
//  Modports : master - checker/bench side, slave - display scanner side
//  Revision : 1.0  initial release
// ============================================================================
interface seg7_status_scan_if;
    logic        test_pass;
    logic        test_err;
    logic [31:0] pc;
    logic [3:0]  seg_en;
    logic [7:0]  seg;

    modport master (output test_pass, output test_err, output pc,
                    input  seg_en,    input  seg);
    modport slave  (input  test_pass, input  test_err, input  pc,
                    output seg_en,    output seg);
endinterface
`default_nettype wire

// File: rtl/seg7_status_scan_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational nibble to active-low seven-segment glyph (0-F),
//             lower-case b and d, dp off.
//  Ports    : i_nibble[3:0] value to show, o_glyph[7:0] {dp,g,f,e,d,c,b,a}
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode (
    input  wire logic [3:0] i_nibble,
    output logic      [7:0] o_glyph
);
    always_comb begin
        o_glyph = 8'hFF;
        case (i_nibble)
            4'h0: o_glyph = 8'hC0;
            4'h1: o_glyph = 8'hF9;
            4'h2: o_glyph = 8'hA4;
            4'h3: o_glyph = 8'hB0;
            4'h4: o_glyph = 8'h99;
            4'h5: o_glyph = 8'h92;
            4'h6: o_glyph = 8'h82;
            4'h7: o_glyph = 8'hF8;
            4'h8: o_glyph = 8'h80;
            4'h9: o_glyph = 8'h90;
            4'hA: o_glyph = 8'h88;
            4'hB: o_glyph = 8'h83;
            4'hC: o_glyph = 8'hC6;
            4'hD: o_glyph = 8'hA1;
            4'hE: o_glyph = 8'h86;
            4'hF: o_glyph = 8'h8E;
            default: o_glyph = 8'hFF;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/seg7_status_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_status_scan
//  Purpose  : Shows the trace checker's status on a 4-digit seven-segment
//             display: blank while running, "SUCC" on pass, the faulting
//             PC[15:0] in hex on error. One digit is driven per SCAN_DIV clks.
//  Ports    : clk    clock
//             reset  synchronous, active-high reset
//             bus    seg7_status_scan_if.slave (test_pass, test_err, pc in;
//                    seg_en, seg out, both active-low)
//  Params   : SCAN_DIV    clk cycles per digit slot (>= 2)
//             BLINK_TICKS slot ticks per blink half-period
//  Macro    : SEG7_ERR_BLINK_EN - blink the error display (off = steady)
//  Revision : 1.0  initial release
// ============================================================================
module seg7_status_scan
    import seg7_status_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 65536,
    parameter int BLINK_TICKS = 256
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seg7_status_scan_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    mode_t            r_mode;
    logic [15:0]      r_err_pc;
    logic [3:0]       r_seg_en;
    logic [7:0]       r_seg;

    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [7:0]       w_hex_glyph;
    logic [7:0]       w_glyph;

    // Only the low half of the PC is ever displayed.
    logic             w_unused_pc_hi;
    assign w_unused_pc_hi = &{1'b0, bus.pc[31:16]};

`ifdef SEG7_ERR_BLINK_EN
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
`else
    localparam int c_unused_blink_ticks = BLINK_TICKS;
`endif

    assign w_tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .o_glyph  (w_hex_glyph)
    );

    // Glyph for the slot about to be shown; uses the mode held before this
    // edge, so a mode change lands on the following tick.
    always_comb begin
        w_nibble = r_err_pc[15:12];
        case (r_idx)
            2'd1:    w_nibble = r_err_pc[11:8];
            2'd2:    w_nibble = r_err_pc[7:4];
            2'd3:    w_nibble = r_err_pc[3:0];
            default: w_nibble = r_err_pc[15:12];
        endcase

        w_glyph = GLYPH_BLANK;
        case (r_mode)
            MODE_DONE: begin
                case (r_idx)
                    2'd0:    w_glyph = GLYPH_S;
                    2'd1:    w_glyph = GLYPH_U;
                    default: w_glyph = GLYPH_C;
                endcase
            end
            MODE_ERR: begin
                w_glyph = w_hex_glyph;
`ifdef SEG7_ERR_BLINK_EN
                if (!r_blink_on) begin
                    w_glyph = GLYPH_BLANK;
                end
`endif
            end
            default: w_glyph = GLYPH_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_mode      <= MODE_RUN;
            r_err_pc    <= 16'h0000;
            r_seg_en    <= DIGIT_EN_OFF;
            r_seg       <= GLYPH_BLANK;
`ifdef SEG7_ERR_BLINK_EN
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
`endif
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);

            // ERR and DONE are terminal until reset; error beats pass.
            case (r_mode)
                MODE_RUN: begin
                    if (bus.test_err) begin
                        r_mode   <= MODE_ERR;
                        r_err_pc <= bus.pc[15:0];
                    end else if (bus.test_pass) begin
                        r_mode <= MODE_DONE;
                    end
                end
                default: r_mode <= r_mode;
            endcase

            if (w_tick) begin
                r_idx    <= r_idx + 2'd1;
                r_seg_en <= digit_enable(r_idx);
                r_seg    <= w_glyph;
`ifdef SEG7_ERR_BLINK_EN
                // Blink state sits at its reset value until ERR is entered,
                // so the first ERR half-period is always ON.
                if (r_mode == MODE_ERR) begin
                    if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                        r_blink_cnt <= '0;
                        r_blink_on  <= ~r_blink_on;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
                    end
                end
`endif
            end
        end
    end

    assign bus.seg_en = r_seg_en;
    assign bus.seg    = r_seg;

endmodule
`default_nettype wire
